// File: rtl/booth_mult_seq_if.sv
`default_nettype none
// ============================================================================
//  booth_mult_seq_if
//  Request/response bundle for the sequential Booth multiplier.
//  Revision: 1.0 - initial release
// ============================================================================
interface booth_mult_seq_if #(
  parameter int MBITS = 16,
  parameter int NBITS = 16
);
  logic                   start;
  logic                   tc;
  logic [MBITS-1:0]       mpd;
  logic [NBITS-1:0]       mpr;
  logic [MBITS+NBITS-1:0] prod;
  logic                   busy;
  logic                   done;

  modport master (output start, tc, mpd, mpr, input prod, busy, done);
  modport slave  (input start, tc, mpd, mpr, output prod, busy, done);
endinterface
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  booth_mult_seq
//  Sequential radix-2 Booth multiplier, signed/unsigned per operation.
//  Optional macro BOOTH_MULT_EARLY_EXIT_EN: collapse trailing no-op steps.
//  Revision: 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
  parameter int MBITS = 16,
  parameter int NBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_mult_seq_if.slave  bus
);

  localparam int c_PW = MBITS + NBITS;
  localparam int c_CW = $clog2(NBITS + 2);
  localparam logic [c_CW-1:0] c_N_TC = c_CW'(NBITS);
  localparam logic [c_CW-1:0] c_N_UN = c_CW'(NBITS + 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CALC = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [MBITS:0]  r_a;
  logic [MBITS:0]  r_m;
  logic [NBITS:0]  r_q;
  logic            r_qm1;
  logic            r_tc;
  logic [c_CW-1:0] r_cnt;
  logic [c_PW-1:0] r_prod;

  logic [MBITS:0]  w_sum;
  logic [MBITS:0]  w_a_nxt;
  logic [NBITS:0]  w_q_nxt;
  logic            w_qm1_nxt;
  logic            w_last;
  logic [c_PW-1:0] w_prod_fin;
  logic            w_busy;
  logic            w_done;

`ifdef BOOTH_MULT_EARLY_EXIT_EN
  logic            w_uniform;
  logic signed [c_PW+2:0] w_sh;
`endif

  // One Booth step: add/sub on the {Q[0], q-1} pair, then arithmetic shift.
  always_comb begin
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
    {w_a_nxt, w_q_nxt, w_qm1_nxt} = {w_sum[MBITS], w_sum, r_q};
    w_last = (r_cnt == c_CW'(1));
`ifdef BOOTH_MULT_EARLY_EXIT_EN
    // Unconsumed bits sit in Q[r_cnt-1:0]; if they all match q-1 no add/sub remains.
    w_uniform = 1'b1;
    for (int i = 0; i <= NBITS; i++) begin
      if ((i < int'(r_cnt)) && (r_q[i] != r_qm1)) begin
        w_uniform = 1'b0;
      end
    end
    w_sh = $signed({r_a, r_q, r_qm1}) >>> r_cnt;
    if (w_uniform) begin
      {w_a_nxt, w_q_nxt, w_qm1_nxt} = w_sh;
      w_last = 1'b1;
    end
`endif
  end

  // Signed runs take one step fewer, so the product sits one bit higher.
  always_comb begin
    if (r_tc) begin
      w_prod_fin = {w_a_nxt[MBITS-1:0], w_q_nxt[NBITS:1]};
    end else begin
      w_prod_fin = {w_a_nxt[MBITS-2:0], w_q_nxt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (bus.start) w_state_nxt = c_S_CALC;
      c_S_CALC: if (w_last)    w_state_nxt = c_S_DONE;
      c_S_DONE: w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_S_CALC);
    w_done = (r_state == c_S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_qm1  <= 1'b0;
      r_tc   <= 1'b0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.start) begin
            r_m   <= {bus.tc & bus.mpd[MBITS-1], bus.mpd};
            r_q   <= {bus.tc & bus.mpr[NBITS-1], bus.mpr};
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_tc  <= bus.tc;
            r_cnt <= bus.tc ? c_N_TC : c_N_UN;
          end
        end
        c_S_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt - c_CW'(1);
          if (w_last) begin
            r_prod <= w_prod_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.prod = r_prod;
  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  tb_booth_mult_seq
//  Directed vectors with hand-computed products and CALC lengths.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

  localparam int MBITS = 16;
  localparam int NBITS = 16;

`ifdef BOOTH_MULT_EARLY_EXIT_EN
  localparam int c_N_S10  = 6;
  localparam int c_N_UFF  = 17;
  localparam int c_N_SFF  = 2;
  localparam int c_N_S8K  = 16;
  localparam int c_N_U35  = 5;
  localparam int c_N_S76  = 5;
  localparam int c_N_ZERO = 1;
  localparam int c_N_ONE  = 3;
`else
  localparam int c_N_S10  = 16;
  localparam int c_N_UFF  = 17;
  localparam int c_N_SFF  = 16;
  localparam int c_N_S8K  = 16;
  localparam int c_N_U35  = 17;
  localparam int c_N_S76  = 16;
  localparam int c_N_ZERO = 16;
  localparam int c_N_ONE  = 16;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   n;
  logic saw_done;

  booth_mult_seq_if #(.MBITS(MBITS), .NBITS(NBITS)) bus ();

  booth_mult_seq #(.MBITS(MBITS), .NBITS(NBITS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic tc, input logic [15:0] mpd, input logic [15:0] mpr);
    @(negedge clk);
    bus.start = 1'b1;
    bus.tc    = tc;
    bus.mpd   = mpd;
    bus.mpr   = mpr;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run(input string tag, input logic tc, input logic [15:0] mpd,
                     input logic [15:0] mpr, input logic [31:0] exp, input int exp_n);
    int cyc;
    start_op(tc, mpd, mpr);
    chk({tag, " busy after accept"}, 64'(bus.busy), 64'd1);
    wait_done(cyc);
    chk({tag, " calc cycles"}, 64'(cyc), 64'(exp_n));
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " prod"}, 64'(bus.prod), 64'(exp));
    @(posedge clk);
    #1;
    chk({tag, " done falls"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.tc      = 1'b0;
    bus.mpd     = '0;
    bus.mpr     = '0;
    repeat (2) @(negedge clk);
    chk("reset prod", 64'(bus.prod), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    run("s10xm10",  1'b1, 16'd10,   16'hFFF6, 32'hFFFFFF9C, c_N_S10);
    run("uFFFFsq",  1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, c_N_UFF);
    run("sFFFFsq",  1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, c_N_SFF);
    run("s8000sq",  1'b1, 16'h8000, 16'h8000, 32'h40000000, c_N_S8K);

    // start held high: operand churn during busy, back-to-back acceptance
    @(negedge clk);
    bus.start = 1'b1;
    bus.tc    = 1'b0;
    bus.mpd   = 16'd3;
    bus.mpr   = 16'd5;
    @(posedge clk);
    #1;
    chk("hs op1 busy", 64'(bus.busy), 64'd1);
    bus.mpd = 16'h9999;
    bus.mpr = 16'h7777;
    wait_done(n);
    chk("hs op1 calc cycles", 64'(n), 64'(c_N_U35));
    chk("hs op1 done", 64'(bus.done), 64'd1);
    chk("hs op1 prod", 64'(bus.prod), 64'd15);
    bus.mpd = 16'd3;
    bus.mpr = 16'd5;
    @(posedge clk);
    #1;
    chk("hs idle done", 64'(bus.done), 64'd0);
    chk("hs idle busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    chk("hs op2 busy", 64'(bus.busy), 64'd1);
    bus.mpd = 16'h1234;
    bus.mpr = 16'h4321;
    wait_done(n);
    chk("hs op2 calc cycles", 64'(n), 64'(c_N_U35));
    chk("hs op2 prod", 64'(bus.prod), 64'd15);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("hs op2 done falls", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    chk("hs no requeue", 64'(bus.busy), 64'd0);

    // asynchronous reset in CALC cycle 8
    start_op(1'b1, 16'd1234, 16'd1);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst prod", 64'(bus.prod), 64'd0);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("rst no done", 64'(saw_done), 64'd0);
    run("s7x6",     1'b1, 16'd7,    16'd6,    32'd42,   c_N_S76);

    run("ee_x0",    1'b1, 16'd1234, 16'd0,    32'd0,    c_N_ZERO);
    run("ee_x1",    1'b1, 16'd1234, 16'd1,    32'd1234, c_N_ONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
